shift_add_mul_ctrl: RTL and testbench

Sequential unsigned multiplier controller that time-shares one WIDTH-bit ripple-carry adder, built from `full_adder` cells, across WIDTH shift-and-add iterations. It accepts operand pairs on a valid/ready handshake and returns a 2·WIDTH-bit product on a second valid/ready handshake. It sits beside the ALU as the multi-cycle MUL unit. The core is stalled on `in_ready`/`out_valid`.

---
 rtl/mul_pkg.sv | 22 ++
 rtl/full_adder.sv | 20 ++
 rtl/ripple_adder.sv | 37 +++
 rtl/shift_add_mul_ctrl.sv | 162 ++++++++++++++++
 tb/tb_shift_add_mul_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// mul_pkg
//   Shared declarations for the shift-and-add multiplier slice.
//   - mul_state_t       : controller state encoding (IDLE, RUN, DONE), 2 bits
//   - MUL_WIDTH_DEFAULT : default operand width of the MUL unit
//   - mul_cnt_width     : width of the iteration counter for a given operand width
package mul_pkg;

  localparam int MUL_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // The counter spans 0..WIDTH-1, so ceil(log2(WIDTH)) bits suffice.
  // A floor of 1 keeps the declaration legal for the smallest widths.
  function automatic int mul_cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder
//   One-bit full adder cell, the building block of the shared ripple adder.
//   Ports:
//     a, b  : addend bits
//     cin   : carry in
//     s     : sum bit
//     cout  : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Classic sum / majority-carry form.
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/ripple_adder.sv
// ripple_adder
//   WIDTH-bit ripple-carry adder built from a chain of full_adder cells.
//   The multiplier controller owns a single instance and reuses it every
//   iteration.
//   Ports:
//     A, B : WIDTH-bit addends
//     cin  : carry into bit 0
//     P    : WIDTH-bit sum
//     cout : carry out of the top bit
module ripple_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] P,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  // Carry ripples from bit 0 upwards; each cell feeds the next.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry[i]),
      .s    (P[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// shift_add_mul_ctrl
//   Sequential unsigned multiplier. One WIDTH-bit ripple adder is shared
//   across WIDTH shift-and-add iterations; operands arrive on a valid/ready
//   handshake and the 2*WIDTH-bit product leaves on a second one.
//
//   Ports:
//     clk        : clock, all state changes on the rising edge
//     rst_n      : asynchronous active-low reset
//     in_valid   : operand pair valid
//     in_ready   : block can accept operands (IDLE only)
//     a, b       : unsigned multiplicand / multiplier, sampled at accept
//     out_valid  : product valid (DONE only)
//     out_ready  : consumer accepts the product
//     product    : registered result a*b, held stable in DONE
//     busy       : controller is not in IDLE
//
//   Optional feature macro: MUL_EARLY_TERM_EN
//     When defined, a RUN cycle whose remaining multiplier bits are all zero
//     finishes immediately by barrel-shifting the partial result into place.
//     When undefined, every operation takes exactly WIDTH RUN cycles and no
//     shifter is built. The product value is the same either way.
module shift_add_mul_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = mul_cnt_width(WIDTH);

  mul_state_t         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;

  logic [WIDTH-1:0]   add_p;
  logic               add_c;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;
  logic               last_iter;

  logic               early_done;
  logic [2*WIDTH-1:0] early_prod;

  // The one shared adder: upper half of the accumulator plus the multiplicand.
  // Carry-in is tied low because only unsigned accumulation is needed.
  ripple_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .A    (acc[2*WIDTH-1:WIDTH]),
    .B    (mcand),
    .cin  (1'b0),
    .P    (add_p),
    .cout (add_c)
  );

  // One shift-and-add step. The low accumulator bit is the current
  // multiplier bit; when it is set the adder result (with its carry as the
  // new top bit) replaces the upper half. The whole thing then shifts right
  // by one, which absorbs the carry and retires the used multiplier bit.
  always_comb begin
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) begin
      sum = {add_c, add_p};
    end
    acc_next  = {sum, acc[WIDTH-1:1]};
    last_iter = (cnt == CW'(WIDTH - 1));
  end

`ifdef MUL_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;
  logic [CW:0]      shamt;

  // After cnt iterations the low WIDTH-cnt accumulator bits are the
  // multiplier bits still to be processed, and the finished partial product
  // sits WIDTH-cnt positions above its final place. If those remaining bits
  // are all zero, no further adds can change the result, so shifting down by
  // WIDTH-cnt yields the final product right now.
  always_comb begin
    rem_mask   = {WIDTH{1'b1}} >> cnt;
    early_done = ((acc[WIDTH-1:0] & rem_mask) == '0);
    shamt      = (CW+1)'(WIDTH) - {1'b0, cnt};
    early_prod = acc >> shamt;
  end
`else
  assign early_done = 1'b0;
  assign early_prod = '0;
`endif

  // Controller FSM. Handshake flags and busy are registered alongside the
  // state so that they depend on state only, never on inputs.
  // IDLE accepts a pair, RUN iterates once per cycle, DONE holds the product
  // until the consumer takes it. Reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      product   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= a;
            acc      <= {{WIDTH{1'b0}}, b};
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        RUN: begin
          if (early_done) begin
            product   <= early_prod;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            acc <= acc_next;
            cnt <= cnt + CW'(1);
            if (last_iter) begin
              product   <= acc_next;
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// tb_shift_add_mul_ctrl
//   Self-checking bench for shift_add_mul_ctrl. An 8-bit instance runs the
//   directed table and the multi-cycle corner sequences; a 32-bit instance
//   runs randomized operand pairs with random output stalls. Expected
//   products come from plain multiplication and expected latencies from the
//   latency rule for the active build.
module tb_shift_add_mul_ctrl;

`ifdef MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk;
  logic rst_n;

  // 8-bit instance
  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  // 32-bit instance
  logic        in_valid32, in_ready32, out_valid32, out_ready32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] product32;

  int testsRun;
  int testsFailed;

  shift_add_mul_ctrl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .product   (product8),
    .busy      (busy8)
  );

  shift_add_mul_ctrl #(.WIDTH(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .a         (a32),
    .b         (b32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .product   (product32),
    .busy      (busy32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency rule: WIDTH cycles, or with early termination one cycle for a
  // zero multiplier and otherwise min(msb_index(b)+2, WIDTH).
  function automatic int expLatency(input logic [63:0] bv, input int w);
    int msb;
    msb = -1;
    for (int i = 0; i < w; i++) begin
      if (bv[i]) msb = i;
    end
    if (!EARLY) return w;
    if (msb < 0) return 1;
    return (msb + 2 < w) ? msb + 2 : w;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one operation on the 8-bit instance: accept, measure cycles until
  // out_valid, hold out_ready low for 'stall' cycles, then hand the product off.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input int stall,
                               output logic [15:0] prod, output int lat);
    @(negedge clk);
    checkOutput("in_ready8 before accept", {63'd0, in_ready8}, 64'd1);
    a8 = av;
    b8 = bv;
    in_valid8 = 1'b1;
    out_ready8 = 1'b0;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    prod = product8;
    repeat (stall) @(posedge clk);
    #1 out_ready8 = 1'b1;
    @(posedge clk);
    #1 out_ready8 = 1'b0;
  endtask

  task automatic applyStimulus32(input logic [31:0] av, input logic [31:0] bv, input int stall,
                                 output logic [63:0] prod, output int lat);
    @(negedge clk);
    a32 = av;
    b32 = bv;
    in_valid32 = 1'b1;
    out_ready32 = 1'b0;
    @(posedge clk);
    #1 in_valid32 = 1'b0;
    lat = 0;
    while (!out_valid32 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    prod = product32;
    repeat (stall) @(posedge clk);
    #1 out_ready32 = 1'b1;
    @(posedge clk);
    #1 out_ready32 = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  initial begin
    vec_t        vecs[8];
    logic [15:0] prod;
    logic [63:0] prod32;
    logic [31:0] ra, rb;
    int          lat;

    testsRun    = 0;
    testsFailed = 0;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143};
    vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'd65025};
    vecs[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
    vecs[3] = '{a: 8'd200, b: 8'd0,   p: 16'd0};
    vecs[4] = '{a: 8'd3,   b: 8'd7,   p: 16'd21};
    vecs[5] = '{a: 8'd1,   b: 8'd1,   p: 16'd1};
    vecs[6] = '{a: 8'd128, b: 8'd2,   p: 16'd256};
    vecs[7] = '{a: 8'd255, b: 8'd128, p: 16'd32640};

    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0;

    // Reset then idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset in_ready",  {63'd0, in_ready8},  64'd1);
    checkOutput("reset out_valid", {63'd0, out_valid8}, 64'd0);
    checkOutput("reset busy",      {63'd0, busy8},      64'd0);
    checkOutput("reset product",   {48'd0, product8},   64'd0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, i % 3, prod, lat);
      checkOutput($sformatf("table[%0d] product", i), {48'd0, prod}, {48'd0, vecs[i].p});
      checkOutput($sformatf("table[%0d] latency", i), 64'(lat), 64'(expLatency({56'd0, vecs[i].b}, 8)));
    end

    // Backpressure: hold DONE for 20 cycles, poke in_valid meanwhile
    @(negedge clk);
    a8 = 8'd50; b8 = 8'd60; in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("bp latency", 64'(lat), 64'(expLatency(64'd60, 8)));
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        a8 = 8'd1; b8 = 8'd1; in_valid8 = 1'b1;
      end
      @(posedge clk);
      #1;
      checkOutput("bp product stable", {48'd0, product8}, 64'd3000);
      checkOutput("bp in_ready low",   {63'd0, in_ready8}, 64'd0);
      checkOutput("bp out_valid held", {63'd0, out_valid8}, 64'd1);
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk);
    #1 out_ready8 = 1'b0;
    checkOutput("bp idle after handshake", {63'd0, in_ready8},  64'd1);
    checkOutput("bp out_valid dropped",    {63'd0, out_valid8}, 64'd0);
    applyStimulus(8'd3, 8'd7, 0, prod, lat);
    checkOutput("bp next product", {48'd0, prod}, 64'd21);

    // Reset in the middle of a run
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd100; in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", {63'd0, out_valid8}, 64'd0);
    checkOutput("midreset busy",      {63'd0, busy8},      64'd0);
    checkOutput("midreset in_ready",  {63'd0, in_ready8},  64'd1);
    checkOutput("midreset product",   {48'd0, product8},   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'd6, 8'd9, 1, prod, lat);
    checkOutput("post-reset product", {48'd0, prod}, 64'd54);
    checkOutput("post-reset latency", 64'(lat), 64'(expLatency(64'd9, 8)));

    // Random regression on the 32-bit instance
    for (int n = 0; n < 700; n++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
      if (n == 0) rb = '0;
      if (n == 1) begin ra = '1; rb = '1; end
      applyStimulus32(ra, rb, $urandom_range(0, 3), prod32, lat);
      checkOutput($sformatf("rand[%0d] product a=%0d b=%0d", n, ra, rb), prod32, {32'd0, ra} * {32'd0, rb});
      checkOutput($sformatf("rand[%0d] latency", n), 64'(lat), 64'(expLatency({32'd0, rb}, 32)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
